// File: rtl/traffic_ctrl_n.sv
// traffic_ctrl_n: N-approach traffic-signal controller.
// Sequences GREEN -> YELLOW -> ALL-RED per phase with tick-based durations,
// demand-driven phase skipping, rest-in-green and a flashing-red mode.
// State, timer, phase and every lamp output are registered, so the lamps
// change on the same clock edge as the state.
module traffic_ctrl_n #(
    parameter int NUM_PHASES = 4,
    parameter int GREEN_T    = 5,
    parameter int YLW_T      = 2,
    parameter int ALLRED_T   = 1,
    parameter int PRESCALE   = 10,
    parameter int TIMER_W    = 8,
    localparam int PH_W      = $clog2(NUM_PHASES)
) (
    input  logic                  ck_i,
    input  logic                  clr_n_i,
    input  logic                  fm_i,
    input  logic                  test_i,
    input  logic [NUM_PHASES-1:0] req_i,
    output logic [NUM_PHASES-1:0] grn_o,
    output logic [NUM_PHASES-1:0] ylw_o,
    output logic [NUM_PHASES-1:0] red_o,
    output logic [PH_W-1:0]       phase_o,
    output logic                  flash_act_o
);

    localparam int PRESC_W = $clog2(PRESCALE);

    localparam logic [TIMER_W-1:0] GREEN_LOAD  = TIMER_W'(GREEN_T - 1);
    localparam logic [TIMER_W-1:0] YLW_LOAD    = TIMER_W'(YLW_T - 1);
    localparam logic [TIMER_W-1:0] ALLRED_LOAD = TIMER_W'(ALLRED_T - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(PRESCALE - 1);
    localparam logic [PH_W-1:0]    PHASE_RST   = PH_W'(NUM_PHASES - 1);

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FLASH  = 2'd3
    } state_t;

    // Registered state
    state_t                state_q,  state_d;
    logic [TIMER_W-1:0]    timer_q,  timer_d;
    logic [PH_W-1:0]       phase_q,  phase_d;
    logic                  toggle_q, toggle_d;
    logic [PRESC_W-1:0]    presc_q,  presc_d;

    // Registered lamp outputs and their next values
    logic [NUM_PHASES-1:0] grn_q, grn_d;
    logic [NUM_PHASES-1:0] ylw_q, ylw_d;
    logic [NUM_PHASES-1:0] red_q, red_d;
    logic                  flash_q, flash_d;

    // Decode helpers
    logic                  tick;
    logic                  expiry;
    logic                  transition;
    logic                  other_req;
    logic [PH_W-1:0]       next_phase;
    logic [NUM_PHASES-1:0] phase_oh_q;   // one-hot of the phase being served now
    logic [NUM_PHASES-1:0] phase_oh_d;   // one-hot of the phase after this edge

    // One-hot decoders for the current and upcoming phase
    generate
        for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_phase_oh
            assign phase_oh_q[gi] = (phase_q == PH_W'(gi));
            assign phase_oh_d[gi] = (phase_d == PH_W'(gi));
        end
    endgenerate

    // A tick is every cycle in test mode, otherwise once per PRESCALE cycles
    assign tick      = test_i | (presc_q == PRESC_LAST);
    assign expiry    = tick & (timer_q == '0);
    // Demand on any approach other than the one currently green
    assign other_req = |(req_i & ~phase_oh_q);

    // Round-robin scan for the next requested phase, starting after the
    // current one; with no demand at all, simply advance by one.
    always_comb begin
        int  idx;
        logic found;
        found      = 1'b0;
        idx        = (int'(phase_q) + 1) % NUM_PHASES;
        next_phase = PH_W'(idx);
        for (int k = 1; k <= NUM_PHASES; k++) begin
            idx = (int'(phase_q) + k) % NUM_PHASES;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                next_phase = PH_W'(idx);
            end
        end
    end

    // Next-state, timer, phase, flash toggle and prescaler decision
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        phase_d    = phase_q;
        toggle_d   = toggle_q;
        transition = 1'b0;

        if (state_q == ST_FLASH) begin
            // Timer is irrelevant while flashing; only FM release leaves
            if (!fm_i) begin
                state_d    = ST_ALLRED;
                timer_d    = ALLRED_LOAD;
                toggle_d   = 1'b0;
                transition = 1'b1;
            end else if (tick) begin
                toggle_d = ~toggle_q;
            end
        end else if (fm_i) begin
            // Flash request overrides any pending expiry; red is lit first
            state_d    = ST_FLASH;
            toggle_d   = 1'b1;
            transition = 1'b1;
        end else if (expiry) begin
            case (state_q)
                ST_ALLRED: begin
                    state_d    = ST_GREEN;
                    timer_d    = GREEN_LOAD;
                    phase_d    = next_phase;
                    transition = 1'b1;
                end
                ST_GREEN: begin
                    if (other_req) begin
                        state_d    = ST_YELLOW;
                        timer_d    = YLW_LOAD;
                        transition = 1'b1;
                    end else begin
                        // Rest in green: nobody else is waiting
                        timer_d = GREEN_LOAD;
                    end
                end
                ST_YELLOW: begin
                    state_d    = ST_ALLRED;
                    timer_d    = ALLRED_LOAD;
                    transition = 1'b1;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else if (tick) begin
            timer_d = timer_q - 1'b1;
        end

        // Prescaler restarts on every state change so each state lasts an
        // exact multiple of PRESCALE cycles; it is parked at 0 in test mode.
        if (test_i || transition || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Lamp decode from the upcoming state so the lamps switch with the state
    always_comb begin
        grn_d   = '0;
        ylw_d   = '0;
        red_d   = '1;
        flash_d = 1'b0;
        case (state_d)
            ST_GREEN: begin
                grn_d = phase_oh_d;
                red_d = ~phase_oh_d;
            end
            ST_YELLOW: begin
                ylw_d = phase_oh_d;
                red_d = ~phase_oh_d;
            end
            ST_FLASH: begin
                red_d   = {NUM_PHASES{toggle_d}};
                flash_d = 1'b1;
            end
            default: begin
                red_d = '1;
            end
        endcase
    end

    // Controller registers; async clear forces the all-red reset picture
    always_ff @(posedge ck_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            state_q  <= ST_ALLRED;
            timer_q  <= ALLRED_LOAD;
            phase_q  <= PHASE_RST;
            toggle_q <= 1'b0;
            presc_q  <= '0;
            grn_q    <= '0;
            ylw_q    <= '0;
            red_q    <= '1;
            flash_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            phase_q  <= phase_d;
            toggle_q <= toggle_d;
            presc_q  <= presc_d;
            grn_q    <= grn_d;
            ylw_q    <= ylw_d;
            red_q    <= red_d;
            flash_q  <= flash_d;
        end
    end

    assign grn_o       = grn_q;
    assign ylw_o       = ylw_q;
    assign red_o       = red_q;
    assign phase_o     = phase_q;
    assign flash_act_o = flash_q;

endmodule
